// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encodings and direction constants for the mod-N counter
package counter_pkg;

  // Mode select encodings on ctrl; 3'b110 and 3'b111 decode as hold
  localparam logic [2:0] CTRL_HOLD   = 3'b000;
  localparam logic [2:0] CTRL_UP     = 3'b001;
  localparam logic [2:0] CTRL_DOWN   = 3'b010;
  localparam logic [2:0] CTRL_BOUNCE = 3'b011;
  localparam logic [2:0] CTRL_LOAD   = 3'b100;
  localparam logic [2:0] CTRL_CLEAR  = 3'b101;

  // Bounce direction flag values
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/modn_onehot_dec.sv
// rtl/modn_onehot_dec.sv - one-hot position decode of the count for LED bar displays
module modn_onehot_dec #(
  parameter int MOD_N = 10,
  parameter int WIDTH = $clog2(MOD_N)
) (
  input  logic [WIDTH-1:0] count_i,
  output logic [MOD_N-1:0] onehot_o
);

  // Each position bit lights when the count equals its index
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < MOD_N; i++) begin
      if (count_i == WIDTH'(i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - parametrised modulo-N up/down/bounce counter with load, clear and tc
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int MOD_N = 10,
  parameter int WIDTH = $clog2(MOD_N),
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             load_err,
  output logic [MOD_N-1:0] onehot
);

  // Boundary values in count width; MOD_N >= 2 keeps CNT_MAX_M1 non-negative
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(MOD_N - 1);
  localparam logic [WIDTH-1:0] CNT_MAX_M1 = WIDTH'(MOD_N - 2);
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  // One extra bit so the range test also works when MOD_N == 2**WIDTH
  localparam logic [WIDTH:0]   MOD_N_EXT  = (WIDTH + 1)'(MOD_N);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             load_err_q, load_err_d;
  logic             at_max, at_zero, load_ok;

  assign at_max  = (count_q == CNT_MAX);
  assign at_zero = (count_q == '0);
  assign load_ok = ({1'b0, load_val} < MOD_N_EXT);

  // Next-state selection by mode; pulses default low so they last one cycle
  always_comb begin
    count_d    = count_q;
    dir_d      = dir_q;
    tc_d       = 1'b0;
    load_err_d = 1'b0;
    case (ctrl)
      CTRL_UP: begin
        if (en) begin
          if (at_max) begin
            tc_d = 1'b1;
            if (WRAP != 0) begin
              count_d = '0;
            end
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end
      CTRL_DOWN: begin
        if (en) begin
          if (at_zero) begin
            tc_d = 1'b1;
            if (WRAP != 0) begin
              count_d = CNT_MAX;
            end
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
      end
      CTRL_BOUNCE: begin
        // Reversal points force the direction regardless of the stored flag
        if (en) begin
          if (at_max) begin
            count_d = CNT_MAX_M1;
            dir_d   = DIR_DOWN;
            tc_d    = 1'b1;
          end else if (at_zero) begin
            count_d = CNT_ONE;
            dir_d   = DIR_UP;
            tc_d    = 1'b1;
          end else if (dir_q == DIR_UP) begin
            count_d = count_q + CNT_ONE;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
      end
      CTRL_LOAD: begin
        if (load_ok) begin
          count_d = load_val;
        end else begin
          load_err_d = 1'b1;
        end
      end
      CTRL_CLEAR: begin
        count_d = '0;
        dir_d   = DIR_UP;
      end
      default: begin
      end
    endcase
  end

  // State and pulse registers; reset clears any pending pulse immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      dir_q      <= DIR_UP;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dir_q      <= dir_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign dir      = dir_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

  modn_onehot_dec #(
    .MOD_N (MOD_N),
    .WIDTH (WIDTH)
  ) u_onehot_dec (
    .count_i  (count_q),
    .onehot_o (onehot)
  );

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised modulo-N up/down counter: the general successor to the fixed mod-10 counter. It supports up, down, bounce (ping-pong), load and clear modes, a count-enable strobe from the clock divider, and either wrap or saturate behaviour at the boundaries. It drives a terminal-count pulse and a one-hot position bus for LED bar and thermometer displays. It sits between the clock-divider strobe and the display logic on the lab board.

## Interface
- `MOD_N`, default 10: modulus, legal range 2..256. Count range is 0..MOD_N-1.
- `WIDTH`, default `$clog2(MOD_N)`: width of the count and load buses.
- `WRAP`, default 1: boundary behaviour. 1 = wrap around; 0 = saturate at the boundary.
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `en`, in, 1: count-advance strobe. Qualifies only the up, down and bounce modes.
- `ctrl`, in, 3: mode select, encoded as follows.
  - 000: hold.
  - 001: up.
  - 010: down.
  - 011: bounce.
  - 100: load.
  - 101: clear.
  - 110 and 111: hold.
- `load_val`, in, WIDTH: value applied in load mode.
- `count`, out, WIDTH: current count (registered).
- `dir`, out, 1: bounce direction (registered). 1 = up, 0 = down.
- `tc`, out, 1: terminal-count pulse (registered).
- `load_err`, out, 1: out-of-range load pulse (registered).
- `onehot`, out, MOD_N: equals `1 << count` (combinational decode of `count`).

## Operation
- **Reset** (`rst_n` low, takes effect immediately, no clock needed): `count`=0, `dir`=1, `tc`=0, `load_err`=0, `onehot`=1.
- **Hold:** all state holds. `tc` and `load_err` return to 0.
- **Up** (advances only when `en`=1):
  - Below MOD_N-1: increment.
  - At MOD_N-1 with WRAP=1: go to 0.
  - At MOD_N-1 with WRAP=0: hold.
- **Down** (advances only when `en`=1):
  - Above 0: decrement.
  - At 0 with WRAP=1: go to MOD_N-1.
  - At 0 with WRAP=0: hold.
- **Bounce** (advances only when `en`=1). Produces the sequence 0,1,…,MOD_N-1,MOD_N-2,…,0,1,… and ignores WRAP.
  - At MOD_N-1: next count is MOD_N-2 and `dir` becomes 0, regardless of the current `dir`.
  - At 0: next count is 1 and `dir` becomes 1.
  - Otherwise: step in the direction given by `dir`.
  - MOD_N=2 toggles between 0 and 1.
- **Load** (independent of `en`):
  - `load_val` < MOD_N: `count` takes `load_val`. `dir` is unchanged.
  - `load_val` ≥ MOD_N: `count` holds and `load_err` is 1 for the next cycle.
- **Clear** (independent of `en`): `count`=0 and `dir`=1.
- **`tc`:** 1 for exactly one cycle after an enabled advance that started at the boundary in the direction of travel:
  - up mode at MOD_N-1;
  - down mode at 0;
  - bounce mode at either reversal point.
  - This applies in both WRAP settings. In saturate mode it pulses on every enabled attempt at the boundary.
- **Outside up, down and bounce:** `en` has no effect.
- **Mode change mid-count:** takes effect on the next edge. No pipeline state is carried over.

## Timing
- `count`, `dir`, `tc` and `load_err` update on the rising edge where the mode and `en` are sampled. Latency is 1 cycle.
- `onehot` follows `count` within the same cycle.
- `tc` and `load_err` are single-cycle pulses. Consecutive qualifying events give consecutive pulses. An example with WRAP=0, `en` held high and the count at its boundary gives `tc` high every cycle.
- **Reset asserted mid-operation:** outputs go to their reset values asynchronously, and any pending pulse is lost.
- **Reset release:** must be synchronised externally. The first active edge after deassertion acts on `ctrl`.

## Structure
- Shared package `counter_pkg`:
  - `CTRL_HOLD`, `CTRL_UP`, `CTRL_DOWN`, `CTRL_BOUNCE`, `CTRL_LOAD`, `CTRL_CLEAR` as 3-bit localparams;
  - `DIR_UP` and `DIR_DOWN` constants.
- Sub-module `modn_onehot_dec`, parameterised by WIDTH and MOD_N, for the `onehot` output. It replaces the per-value thermometer mux chain.
- Next-state logic is one combinational case on `ctrl`, followed by one registered always-block with asynchronous reset.

## Test plan
- **Up wrap** (MOD_N=10, WRAP=1): load 8, then up with `en`=1 for 3 cycles.
  - Required: `count` 9, 0, 1.
  - Required: `tc` high only in the cycle after 9→0.
- **Saturate and down wrap:**
  - WRAP=0, up from 9 for 2 cycles: `count` stays 9 and `tc` pulses twice.
  - WRAP=1, down from 1 for 2 cycles: `count` 0, 9.
- **Bounce** (MOD_N=4) from clear, 8 enabled cycles.
  - Required: `count` 1,2,3,2,1,0,1,2.
  - Required: `dir` falls after the 3 and rises after the 0.
  - Required: `tc` pulses after the 3→2 and 0→1 transitions.
- **Load checks** (MOD_N=10):
  - Load 12 with `count`=5: `count` stays 5 and `load_err` pulses once.
  - Load 7: `count`=7 and `onehot`=10'b0010000000.
- **Enable gating:** up mode with `en`=0 for 5 cycles → `count` unchanged and no `tc`.
- **Asynchronous reset:** drop `rst_n` mid-cycle while counting at 6 → `count`=0, `dir`=1 and `onehot`=1 before the next edge.
